spot_billing_unit: RTL and testbench
====================================

Name: spot_billing_unit

Overview:
- Downstream consumer of the spots register's occupancy vector F[3:0]; one duration counter per parking spot.
- Counts time-base ticks while a spot is occupied.
- On departure, converts the count into a fee.
- Delivers fee records one at a time over a valid/ready interface to the display/payment stage.

Parameters:
UNIT_W, 8, width of per-spot duration counter (ticks); saturates at 2^UNIT_W-1
FEE_W, 12, width of fee output; saturates at 2^FEE_W-1
BASE_FEE, 2, fixed fee charged per stay
RATE, 1, fee per counted tick

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous reset, active-low (0 = reset)
F  input  4  occupancy flags from spots register; bit i=1 means spot i occupied
tick  input  1  one-cycle time-base pulse, one per billing unit
fee_ready  input  1  downstream accepts record when high with fee_valid
fee_valid  output  1  fee record present on fee_spot/fee_units/fee_amount
fee_spot  output  2  index of vacated spot
fee_units  output  UNIT_W  ticks counted for the stay
fee_amount  output  FEE_W  computed fee
drop_err  output  1  sticky: a departure record was lost

Behaviour:
- Reset (RST=0 at a clock edge): F_q, all counters, pending flags, pending units, fee_valid, fee_spot, fee_units, fee_amount and drop_err go to 0. Reset mid-transfer discards held and pending records.
- Edge detect: F_q <= F every cycle. Per spot i:
  - arrive_i = F[i] & ~F_q[i]
  - depart_i = ~F[i] & F_q[i]
- After reset, F_q=0, so any spot already occupied is treated as an arrival in the first cycle.
- Counter cnt_i:
  - On arrive_i: loads 1 if tick else 0.
  - Else while F[i]=1 and tick: increments, saturating at all-ones (no wrap).
  - Else holds.
  - A tick in the depart cycle is not counted.
- Capture: on depart_i, pend_units_i <= cnt_i and pend_i <= 1 at that edge.
  - If pend_i is already 1 and not being cleared that same cycle, the older record is kept, the new one is discarded, and drop_err <= 1.
  - drop_err is cleared only by reset.
- Output stage: "load slot" means fee_valid=0, or fee_valid=1 and fee_ready=1.
  - When a load slot exists and any pend is set, select the lowest index i with pend_i=1.
  - Load fee_spot=i, fee_units=pend_units_i, fee_amount=fee(pend_units_i), fee_valid=1.
  - Clear pend_i in the same edge.
- If a load slot exists and nothing is pending, fee_valid drops to 0 when the current record is accepted.
- Back-to-back: with fee_ready held high, one record per cycle.
- If a capture and a clear target the same spot in the same edge, the capture wins: pend_i stays 1 with the new units.
- Stability: while fee_valid=1 and fee_ready=0, fee_spot, fee_units and fee_amount hold constant.
- Fee arithmetic: BASE_FEE + RATE*units, computed at width FEE_W+UNIT_W+1; result above 2^FEE_W-1 is clamped to all-ones.
- Latency: F[i] falls before edge t (depart seen at t), pend set at t, fee_valid high after edge t+1 if the output was free. Minimum 2 cycles from F falling to fee_valid.
- Simultaneous departures on several spots are all captured in the same cycle and emitted in ascending index order.

Test Plan:
- Reset with RST=0 for 2 cycles, F=0 -> all outputs 0; then F=0001 with 5 ticks, F=0000 -> 2 cycles later fee_valid=1, fee_spot=0, fee_units=5, fee_amount=7.
- F=1111, 3 ticks, F=0000 at once, fee_ready=1 -> four consecutive valid cycles with spots 0,1,2,3, each fee_units=3, fee_amount=5.
- fee_ready=0 with record held (spot 2, units 4) for 10 cycles -> outputs constant; raise fee_ready -> accepted, fee_valid falls next cycle.
- Spot 1 occupied 300 ticks (UNIT_W=8) -> fee_units=255, fee_amount=257. Set RATE=20 -> fee_amount=4095 (clamped).
- fee_ready=0; spot 3 departs (units 2), re-arrives, 6 ticks, departs again while first record still pending -> drop_err=1; emitted record is units 2.
- Spot 0 departs, RST=0 one cycle before fee_valid would rise -> fee_valid stays 0, pend cleared, no record afterward.

Source files
------------

// File: rtl/spot_billing_unit.sv
// Per-spot stay timer and fee generator for four parking spots.
// Departures are queued per spot and emitted in ascending index order over valid/ready.
module spot_billing_unit #(
  parameter int UNIT_W   = 8,
  parameter int FEE_W    = 12,
  parameter int BASE_FEE = 2,
  parameter int RATE     = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        F,
  input  logic              tick,
  input  logic              fee_ready,
  output logic              fee_valid,
  output logic [1:0]        fee_spot,
  output logic [UNIT_W-1:0] fee_units,
  output logic [FEE_W-1:0]  fee_amount,
  output logic              drop_err
);

  localparam int NSPOT  = 4;
  localparam int WIDE_W = FEE_W + UNIT_W + 1;
  localparam logic [UNIT_W-1:0] CNT_MAX = '1;

  function automatic logic [FEE_W-1:0] calc_fee(input logic [UNIT_W-1:0] units);
    logic [WIDE_W-1:0] wide;
    wide = WIDE_W'(BASE_FEE) + WIDE_W'(RATE) * WIDE_W'(units);
    if (|wide[WIDE_W-1:FEE_W]) begin
      calc_fee = '1;
    end else begin
      calc_fee = wide[FEE_W-1:0];
    end
  endfunction

  logic [3:0]        f_q;
  logic [UNIT_W-1:0] cnt_q [NSPOT];
  logic [UNIT_W-1:0] cnt_d [NSPOT];
  logic [3:0]        pend_q, pend_d;
  logic [UNIT_W-1:0] pend_units_q [NSPOT];
  logic [UNIT_W-1:0] pend_units_d [NSPOT];
  logic              fee_valid_q, fee_valid_d;
  logic [1:0]        fee_spot_q, fee_spot_d;
  logic [UNIT_W-1:0] fee_units_q, fee_units_d;
  logic [FEE_W-1:0]  fee_amount_q, fee_amount_d;
  logic              drop_err_q, drop_err_d;

  logic [3:0] arrive_s, depart_s, clear_s;
  logic       load_slot_s, any_pend_s;
  logic [1:0] sel_s;

  // Edge detection and lowest-index pending selection
  always_comb begin
    arrive_s    = F & ~f_q;
    depart_s    = ~F & f_q;
    load_slot_s = ~fee_valid_q | fee_ready;
    any_pend_s  = |pend_q;
    sel_s       = 2'd0;
    for (int i = NSPOT - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_s = 2'(i);
      end else begin
        sel_s = sel_s;
      end
    end
    clear_s = 4'b0000;
    if (load_slot_s && any_pend_s) begin
      clear_s[sel_s] = 1'b1;
    end else begin
      clear_s = 4'b0000;
    end
  end

  // Duration counters and departure capture; a newer departure never overwrites a queued one
  always_comb begin
    drop_err_d = drop_err_q;
    pend_d     = pend_q;
    for (int i = 0; i < NSPOT; i++) begin
      cnt_d[i]        = cnt_q[i];
      pend_units_d[i] = pend_units_q[i];
      if (arrive_s[i]) begin
        cnt_d[i] = {{(UNIT_W-1){1'b0}}, tick};
      end else if (F[i] && tick && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + {{(UNIT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      if (depart_s[i]) begin
        if (pend_q[i] && !clear_s[i]) begin
          drop_err_d = 1'b1;
        end else begin
          pend_d[i]       = 1'b1;
          pend_units_d[i] = cnt_q[i];
        end
      end else if (clear_s[i]) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
    end
  end

  // Output record register: load on a free slot, otherwise hold steady
  always_comb begin
    fee_valid_d  = fee_valid_q;
    fee_spot_d   = fee_spot_q;
    fee_units_d  = fee_units_q;
    fee_amount_d = fee_amount_q;
    if (load_slot_s) begin
      if (any_pend_s) begin
        fee_valid_d  = 1'b1;
        fee_spot_d   = sel_s;
        fee_units_d  = pend_units_q[sel_s];
        fee_amount_d = calc_fee(pend_units_q[sel_s]);
      end else begin
        fee_valid_d  = 1'b0;
      end
    end else begin
      fee_valid_d = fee_valid_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      f_q          <= 4'b0000;
      pend_q       <= 4'b0000;
      fee_valid_q  <= 1'b0;
      fee_spot_q   <= 2'd0;
      fee_units_q  <= '0;
      fee_amount_q <= '0;
      drop_err_q   <= 1'b0;
      for (int i = 0; i < NSPOT; i++) begin
        cnt_q[i]        <= '0;
        pend_units_q[i] <= '0;
      end
    end else begin
      f_q          <= F;
      pend_q       <= pend_d;
      fee_valid_q  <= fee_valid_d;
      fee_spot_q   <= fee_spot_d;
      fee_units_q  <= fee_units_d;
      fee_amount_q <= fee_amount_d;
      drop_err_q   <= drop_err_d;
      for (int i = 0; i < NSPOT; i++) begin
        cnt_q[i]        <= cnt_d[i];
        pend_units_q[i] <= pend_units_d[i];
      end
    end
  end

  assign fee_valid  = fee_valid_q;
  assign fee_spot   = fee_spot_q;
  assign fee_units  = fee_units_q;
  assign fee_amount = fee_amount_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_spot_billing_unit.sv
// Directed bench for spot_billing_unit; a second instance with RATE=20 exercises fee clamping.
module tb_spot_billing_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  F;
  logic        tick;
  logic        fee_ready;
  logic        fee_valid,  fee_valid20;
  logic [1:0]  fee_spot,   fee_spot20;
  logic [7:0]  fee_units,  fee_units20;
  logic [11:0] fee_amount, fee_amount20;
  logic        drop_err,   drop_err20;

  int vectors = 0;
  int miscompares = 0;
  logic [22:0] rec_s, rec20_s;

  assign rec_s   = {fee_valid, fee_spot, fee_units, fee_amount};
  assign rec20_s = {fee_valid20, fee_spot20, fee_units20, fee_amount20};

  always #5 CLK = ~CLK;

  spot_billing_unit u_dut (
    .CLK(CLK), .RST(RST), .F(F), .tick(tick), .fee_ready(fee_ready),
    .fee_valid(fee_valid), .fee_spot(fee_spot), .fee_units(fee_units),
    .fee_amount(fee_amount), .drop_err(drop_err)
  );

  spot_billing_unit #(.RATE(20)) u_dut20 (
    .CLK(CLK), .RST(RST), .F(F), .tick(tick), .fee_ready(fee_ready),
    .fee_valid(fee_valid20), .fee_spot(fee_spot20), .fee_units(fee_units20),
    .fee_amount(fee_amount20), .drop_err(drop_err20)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; F = 4'b0000; tick = 1'b0; fee_ready = 1'b0;
    step(); step();
    vectors++;
    if (rec_s !== 23'd0) begin
      miscompares++; $display("FAIL reset_rec: got %h want %h", rec_s, 23'd0);
    end
    vectors++;
    if ({drop_err, drop_err20, rec20_s} !== 25'd0) begin
      miscompares++; $display("FAIL reset_misc: got %h want %h", {drop_err, drop_err20, rec20_s}, 25'd0);
    end
    RST = 1'b1;
  endtask

  task automatic test_single();
    F = 4'b0001; step();
    do_ticks(5);
    F = 4'b0000; step();
    vectors++;
    if (fee_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_early: got %0d want 0", fee_valid);
    end
    step();
    vectors++;
    if (rec_s !== {1'b1, 2'd0, 8'd5, 12'd7}) begin
      miscompares++; $display("FAIL single_rec: got %h want %h", rec_s, {1'b1, 2'd0, 8'd5, 12'd7});
    end
    fee_ready = 1'b1; step();
    vectors++;
    if (fee_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_drain: got %0d want 0", fee_valid);
    end
  endtask

  task automatic test_back_to_back();
    fee_ready = 1'b1;
    F = 4'b1111; step();
    do_ticks(3);
    F = 4'b0000; step();
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (rec_s !== {1'b1, 2'(k), 8'd3, 12'd5}) begin
        miscompares++; $display("FAIL b2b_rec%0d: got %h want %h", k, rec_s, {1'b1, 2'(k), 8'd3, 12'd5});
      end
    end
    step();
    vectors++;
    if (fee_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_end: got %0d want 0", fee_valid);
    end
  endtask

  task automatic test_hold();
    fee_ready = 1'b0;
    F = 4'b0100; step();
    do_ticks(4);
    F = 4'b0000; step();
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (rec_s !== {1'b1, 2'd2, 8'd4, 12'd6}) begin
        miscompares++; $display("FAIL hold_rec%0d: got %h want %h", k, rec_s, {1'b1, 2'd2, 8'd4, 12'd6});
      end
    end
    fee_ready = 1'b1; step();
    vectors++;
    if (fee_valid !== 1'b0) begin
      miscompares++; $display("FAIL hold_accept: got %0d want 0", fee_valid);
    end
  endtask

  task automatic test_saturate();
    fee_ready = 1'b0;
    F = 4'b0010; step();
    do_ticks(300);
    F = 4'b0000; step();
    step();
    vectors++;
    if (rec_s !== {1'b1, 2'd1, 8'd255, 12'd257}) begin
      miscompares++; $display("FAIL sat_rec: got %h want %h", rec_s, {1'b1, 2'd1, 8'd255, 12'd257});
    end
    vectors++;
    if (rec20_s !== {1'b1, 2'd1, 8'd255, 12'd4095}) begin
      miscompares++; $display("FAIL sat_clamp: got %h want %h", rec20_s, {1'b1, 2'd1, 8'd255, 12'd4095});
    end
    fee_ready = 1'b1; step();
    vectors++;
    if ({fee_valid, fee_valid20} !== 2'b00) begin
      miscompares++; $display("FAIL sat_drain: got %b want 00", {fee_valid, fee_valid20});
    end
  endtask

  task automatic test_drop();
    fee_ready = 1'b0;
    F = 4'b1001; step();
    do_ticks(2);
    F = 4'b1000; step();
    step();
    F = 4'b0000; step();
    vectors++;
    if (drop_err !== 1'b0) begin
      miscompares++; $display("FAIL drop_pre: got %0d want 0", drop_err);
    end
    F = 4'b1000; step();
    do_ticks(6);
    F = 4'b0000; step();
    vectors++;
    if (drop_err !== 1'b1) begin
      miscompares++; $display("FAIL drop_flag: got %0d want 1", drop_err);
    end
    vectors++;
    if (rec_s !== {1'b1, 2'd0, 8'd2, 12'd4}) begin
      miscompares++; $display("FAIL drop_head: got %h want %h", rec_s, {1'b1, 2'd0, 8'd2, 12'd4});
    end
    fee_ready = 1'b1; step();
    vectors++;
    if (rec_s !== {1'b1, 2'd3, 8'd2, 12'd4}) begin
      miscompares++; $display("FAIL drop_kept: got %h want %h", rec_s, {1'b1, 2'd3, 8'd2, 12'd4});
    end
    step();
    vectors++;
    if ({fee_valid, drop_err} !== 2'b01) begin
      miscompares++; $display("FAIL drop_sticky: got %b want 01", {fee_valid, drop_err});
    end
  endtask

  task automatic test_reset_mid();
    fee_ready = 1'b1;
    F = 4'b0001; step();
    do_ticks(1);
    F = 4'b0000; step();
    RST = 1'b0; step();
    vectors++;
    if ({fee_valid, drop_err} !== 2'b00) begin
      miscompares++; $display("FAIL rmid_reset: got %b want 00", {fee_valid, drop_err});
    end
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (fee_valid !== 1'b0) begin
        miscompares++; $display("FAIL rmid_after%0d: got %0d want 0", k, fee_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_saturate();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
